neighbor_link_mux: RTL and testbench
====================================

# neighbor_link_mux

Time-multiplexes the message streams of NUM_LINKS `neighbor_link_to_fifo` instances onto one shared inter-tile channel, and demultiplexes the matching inbound channel back into per-link FIFO inputs.
- Transmit side: pops each link's first-word-fall-through output FIFO under round-robin arbitration, prefixes the link index and holds the frame in a registered output stage.
- Receive side: decodes the link index of each inbound frame and delivers a one-cycle registered pulse to that link's FIFO input.
- Sits directly downstream (transmit) and upstream (receive) of the neighbor links at a tile boundary.

## Interface
Parameters:
- NUM_LINKS, 4, number of multiplexed neighbor links, ≥2.
- PER_DIMENSION_WIDTH, 4, per-axis address width.
- ADDRESS_WIDTH, derived = 3*PER_DIMENSION_WIDTH.
- MSG_WIDTH, derived = ADDRESS_WIDTH+2. Message layout is {odd_flag, increase_flag, root[ADDRESS_WIDTH-1:0]}.
- ID_WIDTH, derived = $clog2(NUM_LINKS).
- FRAME_WIDTH, derived = ID_WIDTH+MSG_WIDTH. Frame layout is {link_id, message}.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- initialize  in  1  synchronous flush at the start of each decoding round.
- link_out_data  in  NUM_LINKS*MSG_WIDTH  per-link FIFO head; link i occupies bits [i*MSG_WIDTH +: MSG_WIDTH].
- link_out_valid  in  NUM_LINKS  per-link FIFO non-empty.
- link_out_ready  out  NUM_LINKS  one-hot pop strobe (rd_en) to each link FIFO.
- chan_out_data  out  FRAME_WIDTH  outbound frame.
- chan_out_valid  out  1  outbound frame valid.
- chan_out_ready  in  1  channel accepts the frame.
- chan_in_data  in  FRAME_WIDTH  inbound frame.
- chan_in_valid  in  1  inbound frame valid.
- chan_in_ready  out  1  tied to 1; the receive side never stalls.
- link_in_data  out  MSG_WIDTH  payload of the last delivered inbound frame, shared by all links.
- link_in_valid  out  NUM_LINKS  one-hot delivery strobe.
- rx_bad_id  out  1  sticky flag: an inbound link_id ≥ NUM_LINKS was received.
- tx_count  out  16  saturating count of transmitted frames.
- rx_count  out  16  saturating count of delivered frames.

## Operation
Transmit:
- The output holding register is "free" when chan_out_valid=0 or (chan_out_valid & chan_out_ready).
- If the register is free, reset=0, initialize=0 and any link_out_valid bit is set, the arbiter grants one link.
  - Winner: first set bit scanning from index ptr upward, wrapping modulo NUM_LINKS.
  - link_out_ready[winner] is driven high combinationally in the same cycle. All other ready bits stay 0, and ready is never high for a link whose valid is 0.
  - On the next edge the register loads {winner, link_out_data[winner]} and chan_out_valid is set to 1.
  - ptr becomes winner+1, wrapping to 0 after NUM_LINKS-1.
- If the register is not free, chan_out_data and chan_out_valid hold unchanged until accepted; no grant is issued.
- If the register is free and no link is requesting, chan_out_valid clears on the next edge.
- tx_count increments by 1 on each load and saturates at 16'hFFFF.

Receive:
- On each edge with chan_in_valid=1 and initialize=0:
  - link_in_data is loaded with the payload bits [MSG_WIDTH-1:0] of chan_in_data.
  - link_in_valid is loaded with the one-hot decode of link_id.
  - rx_count increments, saturating at 16'hFFFF.
- If link_id ≥ NUM_LINKS:
  - link_in_valid is loaded with 0.
  - rx_bad_id is set; it stays set until reset.
  - rx_count does not increment.
- In any cycle without a valid inbound frame, link_in_valid is loaded with 0.

Flush behaviour:
- reset clears ptr, chan_out_valid, chan_out_data, link_in_valid, link_in_data, rx_bad_id, tx_count and rx_count.
- initialize clears ptr, chan_out_valid and link_in_valid, and suppresses grants and deliveries. Any in-flight frame is dropped. Counters and rx_bad_id are kept.

## Timing
- Reset values of outputs:
  - link_out_ready = 0, chan_out_valid = 0, chan_out_data = 0.
  - link_in_valid = 0, link_in_data = 0.
  - rx_bad_id = 0, tx_count = 0, rx_count = 0, chan_in_ready = 1.
- Transmit latency: link pop in cycle t gives chan_out_valid in cycle t+1.
  - Throughput is 1 frame per cycle while chan_out_ready=1.
  - When chan_out_ready=1 and a valid frame is being accepted, the register is refilled in the same cycle (no bubble).
- Receive latency: frame in cycle t gives link_in_valid/link_in_data in cycle t+1.
- Fairness: with all links continuously valid and the channel always ready, the grant order is 0,1,…,NUM_LINKS-1,0,…
- Priority: reset dominates initialize, which dominates normal operation.
- reset or initialize asserted during a stalled frame: the frame is discarded at that edge and no pop occurs in that cycle.

## Test plan
- Reset, then link 2 valid alone with message 14'h0123 → link_out_ready=4'b0100 for exactly 1 cycle; next cycle chan_out_data={2'd2,14'h0123}, chan_out_valid=1, tx_count=1.
- All 4 links valid continuously, chan_out_ready=1 → frames emitted with ids 0,1,2,3,0,1 on consecutive cycles, no bubbles.
- Frame pending and chan_out_ready held 0 for 5 cycles while links stay valid → chan_out_data stable for the stall, link_out_ready=0 throughout; it resumes with the next round-robin id once ready=1.
- Inbound frames {id=1,payload=14'h2005} then {id=3,payload=14'h1000} back-to-back → link_in_valid=4'b0010 then 4'b1000 on consecutive cycles with matching link_in_data; rx_count=2.
- NUM_LINKS=3 instance, inbound id=3 → no link_in_valid bit set, rx_bad_id=1 and stays 1 after initialize, rx_count unchanged.
- initialize pulsed while chan_out_valid=1 and stalled → chan_out_valid=0 next cycle, ptr=0, no link_out_ready in the initialize cycle, counters unchanged.

Source files
------------

// File: rtl/neighbor_link_mux.sv
// neighbor_link_mux: shares one inter-tile channel between NUM_LINKS neighbor
// links. The transmit side round-robin pops the links' first-word-fall-through
// FIFOs into a registered {link_id, message} frame. The receive side steers
// each inbound frame to its link as a one-cycle registered strobe.
module neighbor_link_mux #(
    parameter int NUM_LINKS           = 4,
    parameter int PER_DIMENSION_WIDTH = 4,
    localparam int ADDRESS_WIDTH      = 3 * PER_DIMENSION_WIDTH,
    localparam int MSG_WIDTH          = ADDRESS_WIDTH + 2,
    localparam int ID_WIDTH           = $clog2(NUM_LINKS),
    localparam int FRAME_WIDTH        = ID_WIDTH + MSG_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           initialize,
    input  logic [NUM_LINKS*MSG_WIDTH-1:0] link_out_data,
    input  logic [NUM_LINKS-1:0]           link_out_valid,
    output logic [NUM_LINKS-1:0]           link_out_ready,
    output logic [FRAME_WIDTH-1:0]         chan_out_data,
    output logic                           chan_out_valid,
    input  logic                           chan_out_ready,
    input  logic [FRAME_WIDTH-1:0]         chan_in_data,
    input  logic                           chan_in_valid,
    output logic                           chan_in_ready,
    output logic [MSG_WIDTH-1:0]           link_in_data,
    output logic [NUM_LINKS-1:0]           link_in_valid,
    output logic                           rx_bad_id,
    output logic [15:0]                    tx_count,
    output logic [15:0]                    rx_count
);

    // Round-robin pointer: the link that gets first look in the next grant.
    logic [ID_WIDTH-1:0]  ptr;
    logic                 out_free;
    logic                 any_req;
    logic                 grant_en;
    logic [ID_WIDTH-1:0]  winner;
    logic [MSG_WIDTH-1:0] winner_msg;

    logic [ID_WIDTH-1:0]  in_id;
    logic                 in_id_ok;
    logic [NUM_LINKS-1:0] in_onehot;

    // The receive side has no backpressure path.
    assign chan_in_ready = 1'b1;

    // The holding register can take a new frame when empty or being drained.
    assign out_free = !chan_out_valid || chan_out_ready;
    assign any_req  = |link_out_valid;
    assign grant_en = out_free && any_req && !reset && !initialize;

    // Pick the first requesting link at or after ptr, wrapping around.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves
        // it unassigned; otherwise synthesis infers a latch to hold the old value.
        int  idx;
        logic found;
        idx        = 0;
        found      = 1'b0;
        winner     = ptr;
        for (int off = 0; off < NUM_LINKS; off++) begin
            idx = (int'(ptr) + off) % NUM_LINKS;
            if (!found && link_out_valid[idx]) begin
                winner = ID_WIDTH'(idx);
                found  = 1'b1;
            end
        end
    end

    // Route the winner's FIFO head and its one-hot pop strobe.
    always_comb begin
        winner_msg     = '0;
        link_out_ready = '0;
        for (int i = 0; i < NUM_LINKS; i++) begin
            if (i == int'(winner)) begin
                winner_msg        = link_out_data[i*MSG_WIDTH +: MSG_WIDTH];
                link_out_ready[i] = grant_en;
            end
        end
    end

    // Decode the inbound link_id; ids past the last link are rejected.
    always_comb begin
        in_id     = chan_in_data[FRAME_WIDTH-1 -: ID_WIDTH];
        in_id_ok  = int'(in_id) < NUM_LINKS;
        in_onehot = '0;
        for (int i = 0; i < NUM_LINKS; i++) begin
            if (i == int'(in_id)) begin
                in_onehot[i] = 1'b1;
            end
        end
    end

    // Transmit holding register, round-robin pointer and transmit counter.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            ptr            <= '0;
            chan_out_valid <= 1'b0;
            chan_out_data  <= '0;
            tx_count       <= '0;
        end else if (initialize) begin
            // An in-flight frame is dropped; the data bits are simply ignored.
            ptr            <= '0;
            chan_out_valid <= 1'b0;
        end else if (out_free) begin
            if (any_req) begin
                chan_out_data  <= {winner, winner_msg};
                chan_out_valid <= 1'b1;
                ptr            <= (int'(winner) == NUM_LINKS - 1) ? '0 : winner + 1'b1;
                if (tx_count != 16'hFFFF) begin
                    tx_count <= tx_count + 16'd1;
                end
            end else begin
                chan_out_valid <= 1'b0;
            end
        end
    end

    // Receive delivery register, bad-id flag and receive counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            link_in_valid <= '0;
            link_in_data  <= '0;
            rx_bad_id     <= 1'b0;
            rx_count      <= '0;
        end else if (initialize) begin
            link_in_valid <= '0;
        end else if (chan_in_valid) begin
            link_in_data <= chan_in_data[MSG_WIDTH-1:0];
            if (in_id_ok) begin
                link_in_valid <= in_onehot;
                if (rx_count != 16'hFFFF) begin
                    rx_count <= rx_count + 16'd1;
                end
            end else begin
                link_in_valid <= '0;
                rx_bad_id     <= 1'b1;
            end
        end else begin
            link_in_valid <= '0;
        end
    end

endmodule

// File: tb/tb_neighbor_link_mux.sv
// tb_neighbor_link_mux: drives per-link message queues and inbound frames,
// predicts grants, frames and deliveries from the arbitration rules, and
// checks the DUT through a scoreboard drained by an independent monitor.
module tb_neighbor_link_mux;

    localparam int N  = 4;
    localparam int MW = 14;
    localparam int IW = 2;
    localparam int FW = IW + MW;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            initialize = 1'b0;
    logic [N*MW-1:0] link_out_data = '0;
    logic [N-1:0]    link_out_valid = '0;
    logic [N-1:0]    link_out_ready;
    logic [FW-1:0]   chan_out_data;
    logic            chan_out_valid;
    logic            chan_out_ready = 1'b0;
    logic [FW-1:0]   chan_in_data = '0;
    logic            chan_in_valid = 1'b0;
    logic            chan_in_ready;
    logic [MW-1:0]   link_in_data;
    logic [N-1:0]    link_in_valid;
    logic            rx_bad_id;
    logic [15:0]     tx_count;
    logic [15:0]     rx_count;

    // Three-link instance, used for the out-of-range link_id case.
    logic [3*MW-1:0] l3_out_data = '0;
    logic [2:0]      l3_out_valid = '0;
    logic [2:0]      l3_out_ready;
    logic [FW-1:0]   c3_out_data;
    logic            c3_out_valid;
    logic [FW-1:0]   c3_in_data = '0;
    logic            c3_in_valid = 1'b0;
    logic            c3_in_ready;
    logic            init3 = 1'b0;
    logic [MW-1:0]   l3_in_data;
    logic [2:0]      l3_in_valid;
    logic            bad3;
    logic [15:0]     tx3_count;
    logic [15:0]     rx3_count;

    neighbor_link_mux #(.NUM_LINKS(N), .PER_DIMENSION_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .initialize(initialize),
        .link_out_data(link_out_data), .link_out_valid(link_out_valid),
        .link_out_ready(link_out_ready),
        .chan_out_data(chan_out_data), .chan_out_valid(chan_out_valid),
        .chan_out_ready(chan_out_ready),
        .chan_in_data(chan_in_data), .chan_in_valid(chan_in_valid),
        .chan_in_ready(chan_in_ready),
        .link_in_data(link_in_data), .link_in_valid(link_in_valid),
        .rx_bad_id(rx_bad_id), .tx_count(tx_count), .rx_count(rx_count)
    );

    neighbor_link_mux #(.NUM_LINKS(3), .PER_DIMENSION_WIDTH(4)) dut3 (
        .clk(clk), .reset(reset), .initialize(init3),
        .link_out_data(l3_out_data), .link_out_valid(l3_out_valid),
        .link_out_ready(l3_out_ready),
        .chan_out_data(c3_out_data), .chan_out_valid(c3_out_valid),
        .chan_out_ready(1'b1),
        .chan_in_data(c3_in_data), .chan_in_valid(c3_in_valid),
        .chan_in_ready(c3_in_ready),
        .link_in_data(l3_in_data), .link_in_valid(l3_in_valid),
        .rx_bad_id(bad3), .tx_count(tx3_count), .rx_count(rx3_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state: link FIFOs, expected channel register contents,
    // expected deliveries and expected counter values.
    typedef struct {
        int           due;
        logic [N-1:0] v;
        logic [MW-1:0] d;
    } rx_t;

    logic [MW-1:0] fifo_q [N][$];
    logic [FW-1:0] tx_q[$];
    rx_t           rx_q[$];
    logic [FW-1:0] pending_frame;
    bit            have_pending = 1'b0;
    bit            flush_next   = 1'b0;
    int            m_ptr   = 0;
    int            tx_pend = 0, tx_comm = 0;
    int            rx_pend = 0, rx_comm = 0;

    task automatic drive_links();
        for (int i = 0; i < N; i++) begin
            link_out_valid[i] = fifo_q[i].size() != 0;
            link_out_data[i*MW +: MW] = (fifo_q[i].size() != 0) ? fifo_q[i][0] : MW'($urandom);
        end
    endtask

    // One clock of stimulus plus the model's prediction for that cycle.
    task automatic step(input bit init, input bit rdy, input bit in_v, input logic [FW-1:0] in_d);
        logic [N-1:0] exp_rdy;
        int           win;
        int           id;
        @(posedge clk);
        #1;
        tx_comm = tx_pend;
        rx_comm = rx_pend;
        if (flush_next) begin
            tx_q.delete();
            flush_next = 1'b0;
        end
        if (have_pending) begin
            tx_q.push_back(pending_frame);
            have_pending = 1'b0;
        end
        initialize     = init;
        chan_out_ready = rdy;
        chan_in_valid  = in_v;
        chan_in_data   = in_d;
        drive_links();
        #1;
        exp_rdy = '0;
        win     = -1;
        if (init) begin
            flush_next = 1'b1;
            m_ptr      = 0;
        end else begin
            if (tx_q.size() == 0 || rdy) begin
                for (int off = 0; off < N; off++) begin
                    if (win < 0 && fifo_q[(m_ptr + off) % N].size() != 0) win = (m_ptr + off) % N;
                end
            end
            if (win >= 0) begin
                exp_rdy[win]  = 1'b1;
                pending_frame = {IW'(win), fifo_q[win].pop_front()};
                have_pending  = 1'b1;
                m_ptr         = (win + 1) % N;
                tx_pend++;
            end
            if (in_v) begin
                id = int'(in_d[FW-1 -: IW]);
                rx_q.push_back('{due: cyc + 1, v: N'(1) << id, d: in_d[MW-1:0]});
                rx_pend++;
            end
        end
        check("link_out_ready", link_out_ready, exp_rdy);
    endtask

    task automatic fill_all(input int depth);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < depth; k++) fifo_q[i].push_back(MW'($urandom));
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard.
    rx_t mon_e;
    always @(negedge clk) begin
        if (mon_en) begin
            check("chan_out_valid", chan_out_valid, tx_q.size() != 0);
            if (chan_out_valid && tx_q.size() != 0) begin
                check("chan_out_data", chan_out_data, tx_q[0]);
                if (chan_out_ready) void'(tx_q.pop_front());
            end
            if (rx_q.size() != 0 && rx_q[0].due == cyc) begin
                mon_e = rx_q.pop_front();
                check("link_in_valid", link_in_valid, mon_e.v);
                check("link_in_data", link_in_data, mon_e.d);
            end else begin
                check("link_in_valid_idle", link_in_valid, '0);
            end
            check("tx_count", tx_count, tx_comm);
            check("rx_count", rx_count, rx_comm);
            check("rx_bad_id", rx_bad_id, 1'b0);
        end
    end

    initial begin
        // Reset with requests and an inbound frame present: nothing may leak out.
        reset          = 1'b1;
        link_out_valid = '1;
        link_out_data  = {N{14'h3FFF}};
        chan_out_ready = 1'b1;
        chan_in_valid  = 1'b1;
        chan_in_data   = {2'd1, 14'h1234};
        repeat (2) @(posedge clk);
        #1;
        check("rst_link_out_ready", link_out_ready, '0);
        check("rst_chan_out_valid", chan_out_valid, 1'b0);
        check("rst_chan_out_data", chan_out_data, '0);
        check("rst_link_in_valid", link_in_valid, '0);
        check("rst_link_in_data", link_in_data, '0);
        check("rst_rx_bad_id", rx_bad_id, 1'b0);
        check("rst_tx_count", tx_count, '0);
        check("rst_rx_count", rx_count, '0);
        check("rst_chan_in_ready", chan_in_ready, 1'b1);
        check("rst3_rx_bad_id", bad3, 1'b0);
        link_out_valid = '0;
        chan_in_valid  = 1'b0;
        chan_out_ready = 1'b0;
        reset          = 1'b0;
        mon_en         = 1'b1;

        // Three-link instance: id 3 is out of range.
        @(posedge clk); #1;
        c3_in_valid = 1'b1;
        c3_in_data  = {2'd3, 14'h0155};
        @(posedge clk); #1;
        check("n3_bad_valid", l3_in_valid, 3'b000);
        check("n3_bad_flag", bad3, 1'b1);
        check("n3_bad_count", rx3_count, 16'd0);
        c3_in_data = {2'd2, 14'h0ABC};
        @(posedge clk); #1;
        check("n3_good_valid", l3_in_valid, 3'b100);
        check("n3_good_data", l3_in_data, 14'h0ABC);
        check("n3_good_count", rx3_count, 16'd1);
        c3_in_valid = 1'b0;
        init3       = 1'b1;
        @(posedge clk); #1;
        init3 = 1'b0;
        check("n3_flag_after_init", bad3, 1'b1);
        check("n3_count_after_init", rx3_count, 16'd1);

        // Single request on link 2.
        fifo_q[2].push_back(14'h0123);
        repeat (3) step(1'b0, 1'b1, 1'b0, '0);

        // Frame stalled, then initialize drops it and resets the pointer.
        fifo_q[0].push_back(MW'($urandom));
        step(1'b0, 1'b0, 1'b0, '0);
        fill_all(1);
        repeat (2) step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        repeat (6) step(1'b0, 1'b1, 1'b0, '0);

        // All links requesting, channel always ready: strict rotation.
        fill_all(2);
        repeat (10) step(1'b0, 1'b1, 1'b0, '0);

        // Stall for five cycles with links still valid.
        fill_all(3);
        repeat (2) step(1'b0, 1'b1, 1'b0, '0);
        repeat (5) step(1'b0, 1'b0, 1'b0, '0);
        repeat (12) step(1'b0, 1'b1, 1'b0, '0);

        // Back-to-back inbound frames.
        step(1'b0, 1'b1, 1'b1, {2'd1, 14'h2005});
        step(1'b0, 1'b1, 1'b1, {2'd3, 14'h1000});
        repeat (2) step(1'b0, 1'b1, 1'b0, '0);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            bit init_now;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 2) == 0 && fifo_q[i].size() < 6) fifo_q[i].push_back(MW'($urandom));
            init_now = $urandom_range(0, 49) == 0;
            step(init_now, init_now ? 1'b0 : 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), FW'($urandom));
        end

        // Drain everything that is still queued.
        repeat (40) step(1'b0, 1'b1, 1'b0, '0);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        check("tx_drained", tx_q.size(), 0);
        check("rx_drained", rx_q.size(), 0);
        check("links_drained", fifo_q[0].size() + fifo_q[1].size() + fifo_q[2].size() + fifo_q[3].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
